// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin process scheduler, quantum counted in retired instructions.
// ESCALONADOR_QUANTUM_PROG_EN adds quantum_cfg (slice length) and trocas_total.
module escalonador_rr #(
  parameter int unsigned MAX_PROC  = 10,
  parameter int unsigned QUANTUM   = 16,
  parameter int unsigned PROC_SPAN = 300,
  parameter logic [5:0]  OP_IN     = 6'b011101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic [3:0]  num_processos,
  input  logic        instr_valida,
  input  logic [5:0]  opcode,
  input  logic        fim_processo,
  input  logic        io_pronto,
  input  logic        troca_ack,
`ifdef ESCALONADOR_QUANTUM_PROG_EN
  input  logic [7:0]  quantum_cfg,
  output logic [15:0] trocas_total,
`endif
  output logic        troca_contexto,
  output logic [3:0]  processo_atual,
  output logic [3:0]  proximo_processo,
  output logic [31:0] pc_base,
  output logic        ocioso,
  output logic        todos_fim
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_SELECT, S_SWITCH, S_HALTED
  } state_t;

  localparam logic [1:0] LIVRE  = 2'd0;
  localparam logic [1:0] PRONTO = 2'd1;
  localparam logic [1:0] BLOQ   = 2'd2;
  localparam logic [1:0] FIM    = 2'd3;
  localparam logic [3:0] MAXP   = 4'(MAX_PROC);
  localparam logic [7:0] QDEF   = 8'(QUANTUM);

  state_t r_state, w_next;
  logic [1:0]  r_tab [1:MAX_PROC];
  logic [3:0]  r_n, r_atual, r_prox;
  logic [7:0]  r_cnt;
  logic [31:0] r_pc;
  logic [MAX_PROC:1] w_pronto, w_bloq;
  logic        w_found, w_go, w_is_in, w_qexp, w_ev;
  logic [3:0]  w_sel, w_cand, w_unblk, w_nclamp;
  logic [7:0]  w_qlen;

`ifdef ESCALONADOR_QUANTUM_PROG_EN
  logic [7:0]  r_quant;
  logic [15:0] r_trocas;
  assign w_qlen       = r_quant;
  assign trocas_total = r_trocas;
`else
  assign w_qlen = QDEF;
`endif

  assign w_nclamp = (num_processos > MAXP) ? MAXP : num_processos;
  assign w_go     = habilita && (num_processos != 4'd0);
  assign w_is_in  = instr_valida && (opcode == OP_IN);
  assign w_qexp   = instr_valida && (r_cnt == w_qlen - 8'd1);
  assign w_ev     = fim_processo || w_is_in || w_qexp;

  always_comb begin
    w_pronto = '0;
    w_bloq   = '0;
    for (int i = 1; i <= int'(MAX_PROC); i++) begin
      w_pronto[i] = (r_tab[i] == PRONTO);
      w_bloq[i]   = (r_tab[i] == BLOQ);
    end
  end

  always_comb begin
    w_unblk = 4'd0;
    for (int i = int'(MAX_PROC); i >= 1; i--)
      if (w_bloq[i]) w_unblk = 4'(i);
  end

  // scan starts after the running id and wraps N -> 1
  always_comb begin
    w_found = 1'b0;
    w_sel   = 4'd0;
    w_cand  = r_atual;
    for (int k = 0; k < int'(MAX_PROC); k++) begin
      w_cand = (w_cand >= r_n) ? 4'd1 : w_cand + 4'd1;
      if (!w_found && w_pronto[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_go) w_next = S_SELECT;
      S_RUN:    if (w_ev) w_next = S_SELECT;
      S_SELECT: begin
        if (w_found)
          w_next = (w_sel == r_atual) ? S_RUN : S_SWITCH;
        else if (w_bloq == '0)
          w_next = S_HALTED;
      end
      S_SWITCH: if (troca_ack) w_next = S_RUN;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    troca_contexto = (r_state == S_SWITCH);
    todos_fim      = (r_state == S_HALTED);
    ocioso         = (r_state == S_SELECT) && !w_found && (w_bloq != '0);
  end

  assign processo_atual   = r_atual;
  assign proximo_processo = r_prox;
  assign pc_base          = r_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_n     <= 4'd0;
      r_atual <= 4'd0;
      r_prox  <= 4'd0;
      r_cnt   <= 8'd0;
      r_pc    <= 32'd0;
      for (int i = 1; i <= int'(MAX_PROC); i++) r_tab[i] <= LIVRE;
`ifdef ESCALONADOR_QUANTUM_PROG_EN
      r_quant  <= 8'd0;
      r_trocas <= 16'd0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: if (w_go) begin
          r_n     <= w_nclamp;
          r_atual <= 4'd0;
          for (int i = 1; i <= int'(MAX_PROC); i++)
            r_tab[i] <= (4'(i) <= w_nclamp) ? PRONTO : LIVRE;
`ifdef ESCALONADOR_QUANTUM_PROG_EN
          r_quant <= (quantum_cfg == 8'd0) ? QDEF : quantum_cfg;
`endif
        end
        S_RUN: begin
          if (instr_valida && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          for (int i = 1; i <= int'(MAX_PROC); i++)
            if (4'(i) == r_atual) begin
              if (fim_processo)  r_tab[i] <= FIM;
              else if (w_is_in)  r_tab[i] <= BLOQ;
            end
        end
        S_SELECT: if (w_found) begin
          if (w_sel == r_atual) r_cnt <= 8'd0;
          else begin
            r_prox <= w_sel;
            r_pc   <= 32'(w_sel) * 32'(PROC_SPAN);
          end
        end
        S_SWITCH: if (troca_ack) begin
          r_atual <= r_prox;
          r_cnt   <= 8'd0;
`ifdef ESCALONADOR_QUANTUM_PROG_EN
          r_trocas <= r_trocas + 16'd1;
`endif
        end
        default: ;
      endcase
      // the running entry is PRONTO, so this never collides with a RUN update
      if (io_pronto && w_bloq != '0 &&
          r_state != S_IDLE && r_state != S_HALTED)
        for (int i = 1; i <= int'(MAX_PROC); i++)
          if (4'(i) == w_unblk) r_tab[i] <= PRONTO;
    end
  end

endmodule

// File: tb/tb_escalonador_rr.sv
// tb_escalonador_rr: directed scenarios with a dispatch-order scoreboard.
// Build with ESCALONADOR_QUANTUM_PROG_EN to exercise the programmable slice.
module tb_escalonador_rr;

  localparam int QUANT = 4;
  localparam int SPAN  = 300;
  localparam logic [5:0] OPIN = 6'b011101;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic habilita = 1'b0;
  logic [3:0] num_processos = 4'd0;
  logic instr_valida = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic fim_processo = 1'b0;
  logic io_pronto = 1'b0;
  logic troca_ack = 1'b0;
  logic troca_contexto, ocioso, todos_fim;
  logic [3:0] processo_atual, proximo_processo;
  logic [31:0] pc_base;
`ifdef ESCALONADOR_QUANTUM_PROG_EN
  logic [7:0] quantum_cfg = 8'd0;
  logic [15:0] trocas_total;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  escalonador_rr #(.QUANTUM(QUANT), .PROC_SPAN(SPAN)) dut (
    .clock(clock), .reset(reset), .habilita(habilita),
    .num_processos(num_processos), .instr_valida(instr_valida),
    .opcode(opcode), .fim_processo(fim_processo),
    .io_pronto(io_pronto), .troca_ack(troca_ack),
`ifdef ESCALONADOR_QUANTUM_PROG_EN
    .quantum_cfg(quantum_cfg), .trocas_total(trocas_total),
`endif
    .troca_contexto(troca_contexto), .processo_atual(processo_atual),
    .proximo_processo(proximo_processo), .pc_base(pc_base),
    .ocioso(ocioso), .todos_fim(todos_fim)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_troca"}, 32'(troca_contexto), 0);
    check({tag, "_atual"}, 32'(processo_atual), 0);
    check({tag, "_prox"}, 32'(proximo_processo), 0);
    check({tag, "_pc"}, pc_base, 0);
    check({tag, "_ocioso"}, 32'(ocioso), 0);
    check({tag, "_fim"}, 32'(todos_fim), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    habilita = 1'b0;
    instr_valida = 1'b0;
    opcode = 6'd0;
    fim_processo = 1'b0;
    io_pronto = 1'b0;
    troca_ack = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic start(input logic [3:0] n);
    num_processos = n;
    habilita = 1'b1;
    @(negedge clock);
    habilita = 1'b0;
  endtask

  task automatic expect_switch(input int lat_exp);
    int lat;
    int id;
    lat = 0;
    while (!troca_contexto && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    check("troca_seen", 32'(troca_contexto), 1);
    if (troca_contexto) begin
      id = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      check("proximo", 32'(proximo_processo), 32'(id));
      check("pc_base", pc_base, 32'(id * SPAN));
      if (lat_exp >= 0) check("latency", 32'(lat), 32'(lat_exp));
      troca_ack = 1'b1;
      @(negedge clock);
      troca_ack = 1'b0;
      check("atual", 32'(processo_atual), 32'(id));
      check("troca_low", 32'(troca_contexto), 0);
    end
  endtask

  initial begin
    bit saw;
    // N=0 keeps the scheduler idle
    do_reset();
    num_processos = 4'd0;
    habilita = 1'b1;
    repeat (5) @(negedge clock);
    habilita = 1'b0;
    check_zero("n0");

    // N=3 round robin 1,2,3,1,2
    do_reset();
    instr_valida = 1'b1;
    exp_q = '{1, 2, 3, 1, 2};
    start(4'd3);
    expect_switch(-1);
    repeat (4) expect_switch(QUANT + 1);

    // IN blocks 1, io_pronto lets it back after 2's slice
    do_reset();
    instr_valida = 1'b1;
    exp_q = '{1, 2, 1};
    start(4'd2);
    expect_switch(-1);
    opcode = OPIN;
    @(negedge clock);
    opcode = 6'd0;
    expect_switch(-1);
    io_pronto = 1'b1;
    @(negedge clock);
    io_pronto = 1'b0;
    check("io_ocioso", 32'(ocioso), 0);
    expect_switch(-1);

    // N=1: blocked -> idle, wake without a switch request
    do_reset();
    instr_valida = 1'b1;
    exp_q = '{1};
    start(4'd1);
    expect_switch(-1);
    opcode = OPIN;
    @(negedge clock);
    opcode = 6'd0;
    @(negedge clock);
    check("n1_ocioso", 32'(ocioso), 1);
    check("n1_troca", 32'(troca_contexto), 0);
    io_pronto = 1'b1;
    @(negedge clock);
    io_pronto = 1'b0;
    check("n1_wake", 32'(ocioso), 0);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (troca_contexto) saw = 1'b1;
    end
    check("n1_noswitch", 32'(saw), 0);
    check("n1_atual", 32'(processo_atual), 1);

    // fim beats IN; last fim halts everything
    do_reset();
    instr_valida = 1'b1;
    exp_q = '{1, 2};
    start(4'd2);
    expect_switch(-1);
    fim_processo = 1'b1;
    opcode = OPIN;
    @(negedge clock);
    fim_processo = 1'b0;
    opcode = 6'd0;
    expect_switch(-1);
    fim_processo = 1'b1;
    @(negedge clock);
    fim_processo = 1'b0;
    for (int i = 0; i < 10 && !todos_fim; i++) @(negedge clock);
    check("halt_fim", 32'(todos_fim), 1);
    check("halt_ocioso", 32'(ocioso), 0);
    habilita = 1'b1;
    io_pronto = 1'b1;
    fim_processo = 1'b1;
    repeat (4) @(negedge clock);
    habilita = 1'b0;
    io_pronto = 1'b0;
    fim_processo = 1'b0;
    check("halt_hold", 32'(todos_fim), 1);
    check("halt_troca", 32'(troca_contexto), 0);

    // ack withheld, then async reset mid-switch
    do_reset();
    instr_valida = 1'b1;
    exp_q = '{1};
    start(4'd3);
    expect_switch(-1);
    for (int i = 0; i < 20 && !troca_contexto; i++) @(negedge clock);
    repeat (10) begin
      check("hold_troca", 32'(troca_contexto), 1);
      check("hold_prox", 32'(proximo_processo), 2);
      check("hold_pc", pc_base, 600);
      @(negedge clock);
    end
    reset = 1'b0;
    #1;
    check_zero("async");
    @(negedge clock);
    check_zero("async_idle");

    // clamp: 15 loaded -> 10, wraps 10 -> 1
    do_reset();
    instr_valida = 1'b1;
    for (int i = 1; i <= 10; i++) exp_q.push_back(i);
    exp_q.push_back(1);
    start(4'd15);
    expect_switch(-1);
    repeat (10) expect_switch(QUANT + 1);

`ifdef ESCALONADOR_QUANTUM_PROG_EN
    do_reset();
    quantum_cfg = 8'd2;
    instr_valida = 1'b1;
    exp_q = '{1, 2, 1, 2, 1};
    start(4'd2);
    expect_switch(-1);
    repeat (4) expect_switch(3);
    check("trocas_total", 32'(trocas_total), 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/escalonador_rr.md
Name: escalonador_rr

Overview:
- Round-robin process scheduler for the multiprogrammed CPU. Tracks up to MAX_PROC user processes (ids 1..N; id 0 = OS/BIOS).
- Counts the quantum in retired instructions. Blocks a process on `in` and retires it on end-of-process.
- Requests context switches from the CPU through a req/ack handshake. Sits beside the PC-select logic; replaces the ad-hoc quantum counter and pc-range process decoding.

Parameters:
MAX_PROC, 10, max user processes (process-table depth)
QUANTUM, 16, retired instructions per time slice
PROC_SPAN, 300, instruction-memory words per process region
OP_IN, 6'b011101, opcode of the IN instruction (blocks process)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset
habilita  in  1  BIOS finished; scheduling allowed
num_processos  in  4  loaded process count, sampled on IDLE exit; clamped to MAX_PROC
instr_valida  in  1  one instruction retired this cycle (not halted)
opcode  in  6  opcode of the retiring instruction
fim_processo  in  1  current process executed its end instruction
io_pronto  in  1  1-cycle pulse, pending input completed
troca_ack  in  1  CPU finished save/restore sequence
troca_contexto  out  1  switch request, held until acked
processo_atual  out  4  running process id
proximo_processo  out  4  process selected for dispatch
pc_base  out  32  proximo_processo*PROC_SPAN, zero-extended
ocioso  out  1  no runnable process, at least one blocked
todos_fim  out  1  all loaded processes finished

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, quantum counter 0, every table entry LIVRE.
- Table entry states (2 bits): LIVRE, PRONTO, BLOQUEADO, FINALIZADO.
- FSM states: IDLE, RUN, SELECT, SWITCH, HALTED.
- IDLE:
  - When habilita=1 and num_processos≥1: entries 1..N become PRONTO, processo_atual=0, go to SELECT.
  - num_processos=0: stay in IDLE.
- RUN:
  - Counter increments on instr_valida; 8-bit, saturating.
  - Event priority in the same cycle: fim_processo > IN block > quantum expiry.
  - fim_processo=1: entry becomes FINALIZADO, go to SELECT.
  - instr_valida=1 and opcode==OP_IN: entry becomes BLOQUEADO, go to SELECT.
  - Counter reaches QUANTUM-1 and instr_valida=1: entry stays PRONTO, go to SELECT.
- SELECT (1 cycle per decision):
  - Combinational scan from processo_atual+1, wrapping N→1, for the first PRONTO entry.
  - Found id ≠ processo_atual: proximo_processo=id, pc_base valid, troca_contexto=1 next cycle, go to SWITCH.
  - Found id == processo_atual (sole runnable): no switch; counter cleared, back to RUN.
  - None PRONTO, some BLOQUEADO: ocioso=1, stay in SELECT.
  - All FINALIZADO: go to HALTED, todos_fim=1.
- SWITCH:
  - troca_contexto held high until troca_ack=1.
  - On ack: processo_atual<=proximo_processo, counter cleared, troca_contexto=0, go to RUN.
  - proximo_processo and pc_base are stable while troca_contexto=1.
- io_pronto (any state except IDLE/HALTED):
  - Lowest-numbered BLOQUEADO entry becomes PRONTO.
  - If in SELECT with ocioso=1, ocioso drops and selection proceeds the next cycle.
  - Ignored when no entry is BLOQUEADO.
- io_pronto in the same cycle as a RUN event: both are applied. The unblocked process is eligible in the following SELECT.
- HALTED: holds until reset; all inputs ignored.
- Inputs fim_processo/instr_valida are ignored outside RUN.
- pc_base uses a constant multiply, 32-bit result.

Optional Feature:
- Macro: ESCALONADOR_QUANTUM_PROG_EN.
- Defined:
  - Adds input port quantum_cfg [7:0], sampled on IDLE exit.
  - Value 0 selects QUANTUM; otherwise it is the slice length.
  - Adds output trocas_total [15:0], incremented on every acked switch and wrapping at 16'hFFFF→0.
- Undefined: neither port exists; slice is fixed at QUANTUM.

Test Plan:
- N=3, QUANTUM=4, continuous instr_valida, immediate ack → dispatch order 1,2,3,1,…; troca_contexto rises 4 retirements after each RUN entry; pc_base=300,600,900.
- N=2, process 1 retires OP_IN → entry 1 BLOQUEADO, switch to 2. io_pronto → 1 runs after 2's quantum.
- N=1, IN executed → ocioso=1, no troca_contexto. io_pronto → ocioso=0, process 1 resumes without a switch request.
- N=2, fim_processo and OP_IN in the same cycle → entry FINALIZADO (not BLOQUEADO). After 2 finishes → todos_fim=1, HALTED.
- Ack withheld 10 cycles → troca_contexto, proximo_processo, pc_base constant. reset=0 mid-SWITCH → all outputs 0 immediately, IDLE.
- With ESCALONADOR_QUANTUM_PROG_EN, quantum_cfg=2, N=2 → switch every 2 retirements; trocas_total=5 after 5 acks.
